// File: rtl/cnt_share_ctrl.sv
// cnt_share_ctrl: round-robin time-sharing of one up-counter among NREQ requesters
module cnt_share_ctrl #(
  parameter int NREQ = 4,
  parameter int CW   = 8,
  parameter int IW   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   load_val,
  input  logic                 abort,
  output logic [NREQ-1:0]      grant,
  output logic [IW-1:0]        owner,
  output logic                 busy,
  output logic [CW-1:0]        q_out,
  output logic                 done,
  output logic [NREQ-1:0]      ack
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] tc;
  logic [IW-1:0] sel, idx;
  logic hit;
  // descending scan so the nearest requester after owner is the last one assigned
  always_comb begin
    sel = owner;
    idx = owner;
    hit = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(owner) + k) % NREQ);
      if (req[idx]) begin
        sel = idx;
        hit = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (hit ? RUN : IDLE) :
               state == RUN  ? (abort ? IDLE : (q_out == tc ? DONE : RUN)) : IDLE;
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    ack  = state == DONE ? grant : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      owner <= IW'(NREQ - 1);
      grant <= '0;
      tc    <= '0;
      q_out <= '0;
    end else if (state == IDLE && hit) begin
      owner <= sel;
      grant <= {{(NREQ-1){1'b0}}, 1'b1} << sel;
      tc    <= load_val[sel*CW +: CW];
      q_out <= '0;
    end else if (state == RUN) begin
      if (abort) grant <= '0;
      else if (q_out != tc) q_out <= q_out + 1'b1;
    end else if (state == DONE) begin
      grant <= '0;
    end
endmodule

// File: tb/tb_cnt_share_ctrl.sv
// tb_cnt_share_ctrl: directed self-checking bench for cnt_share_ctrl
module tb_cnt_share_ctrl;
  localparam int NREQ = 4, CW = 8, IW = 2;
  logic clk = 1'b0, reset_n = 1'b1, abort = 1'b0;
  logic [NREQ-1:0] req = '0, grant, ack;
  logic [NREQ*CW-1:0] load_val = '0;
  logic [IW-1:0] owner;
  logic busy, done;
  logic [CW-1:0] q_out;
  logic [17:0] st;
  logic [17:0] ex;
  int n_cmp = 0, n_err = 0;
  cnt_share_ctrl #(.NREQ(NREQ), .CW(CW), .IW(IW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .load_val(load_val), .abort(abort),
    .grant(grant), .owner(owner), .busy(busy), .q_out(q_out), .done(done), .ack(ack)
  );
  assign st = {grant, busy, q_out, done, ack};
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask
  task automatic test_reset();
    #2 reset_n = 1'b0;
    step();
    step();
    n_cmp++; if (st !== 18'd0) begin n_err++; $display("FAIL reset_status got %h want %h", st, 18'd0); end
    n_cmp++; if (owner !== 2'd3) begin n_err++; $display("FAIL reset_owner got %0d want 3", owner); end
    reset_n = 1'b1;
  endtask
  task automatic test_single();
    load_val[0 +: CW] = 8'd3;
    req = 4'b0001;
    step();
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      ex = {4'b0001, 1'b1, 8'(i), 1'b0, 4'b0000};
      n_cmp++; if (st !== ex) begin n_err++; $display("FAIL single_run%0d got %h want %h", i, st, ex); end
      step();
    end
    ex = {4'b0001, 1'b1, 8'd3, 1'b1, 4'b0001};
    n_cmp++; if (st !== ex) begin n_err++; $display("FAIL single_done got %h want %h", st, ex); end
    n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL single_owner got %0d want 0", owner); end
    step();
    ex = {4'b0000, 1'b0, 8'd3, 1'b0, 4'b0000};
    n_cmp++; if (st !== ex) begin n_err++; $display("FAIL single_idle got %h want %h", st, ex); end
  endtask
  task automatic test_tc0();
    load_val[1*CW +: CW] = 8'd0;
    req = 4'b0010;
    step();
    req = 4'b0000;
    ex = {4'b0010, 1'b1, 8'd0, 1'b0, 4'b0000};
    n_cmp++; if (st !== ex) begin n_err++; $display("FAIL tc0_run got %h want %h", st, ex); end
    step();
    ex = {4'b0010, 1'b1, 8'd0, 1'b1, 4'b0010};
    n_cmp++; if (st !== ex) begin n_err++; $display("FAIL tc0_done got %h want %h", st, ex); end
    n_cmp++; if (owner !== 2'd1) begin n_err++; $display("FAIL tc0_owner got %0d want 1", owner); end
    step();
    n_cmp++; if (st !== 18'd0) begin n_err++; $display("FAIL tc0_idle got %h want %h", st, 18'd0); end
  endtask
  task automatic test_round_robin();
    apply_reset();
    load_val = {8'd1, 8'd1, 8'd1, 8'd1};
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step();
      ex = {4'(1 << (g % 4)), 1'b1, 8'd0, 1'b0, 4'b0000};
      n_cmp++; if (st !== ex) begin n_err++; $display("FAIL rr%0d_run0 got %h want %h", g, st, ex); end
      step();
      ex = {4'(1 << (g % 4)), 1'b1, 8'd1, 1'b0, 4'b0000};
      n_cmp++; if (st !== ex) begin n_err++; $display("FAIL rr%0d_run1 got %h want %h", g, st, ex); end
      step();
      ex = {4'(1 << (g % 4)), 1'b1, 8'd1, 1'b1, 4'(1 << (g % 4))};
      n_cmp++; if (st !== ex) begin n_err++; $display("FAIL rr%0d_done got %h want %h", g, st, ex); end
      step();
      ex = {4'b0000, 1'b0, 8'd1, 1'b0, 4'b0000};
      n_cmp++; if (st !== ex) begin n_err++; $display("FAIL rr%0d_idle got %h want %h", g, st, ex); end
    end
    req = 4'b0000;
    step();
  endtask
  task automatic test_abort();
    load_val[0 +: CW] = 8'd10;
    load_val[1*CW +: CW] = 8'd2;
    req = 4'b0001;
    step();
    for (int i = 1; i <= 4; i++) step();
    ex = {4'b0001, 1'b1, 8'd4, 1'b0, 4'b0000};
    n_cmp++; if (st !== ex) begin n_err++; $display("FAIL abort_pre got %h want %h", st, ex); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    ex = {4'b0000, 1'b0, 8'd4, 1'b0, 4'b0000};
    n_cmp++; if (st !== ex) begin n_err++; $display("FAIL abort_post got %h want %h", st, ex); end
    req = 4'b0011;
    step();
    ex = {4'b0010, 1'b1, 8'd0, 1'b0, 4'b0000};
    n_cmp++; if (st !== ex) begin n_err++; $display("FAIL abort_next got %h want %h", st, ex); end
    n_cmp++; if (owner !== 2'd1) begin n_err++; $display("FAIL abort_owner got %0d want 1", owner); end
    abort = 1'b1;
    req = 4'b0000;
    step();
    abort = 1'b0;
    n_cmp++; if (st !== 18'd0) begin n_err++; $display("FAIL abort_second got %h want %h", st, 18'd0); end
  endtask
  task automatic test_full_range();
    load_val[2*CW +: CW] = 8'd255;
    req = 4'b0100;
    step();
    req = 4'b0000;
    load_val[2*CW +: CW] = 8'd5;
    ex = {4'b0100, 1'b1, 8'd0, 1'b0, 4'b0000};
    n_cmp++; if (st !== ex) begin n_err++; $display("FAIL full_q0 got %h want %h", st, ex); end
    for (int i = 1; i < 256; i++) begin
      step();
      ex = {4'b0100, 1'b1, 8'(i), 1'b0, 4'b0000};
      n_cmp++; if (st !== ex) begin n_err++; $display("FAIL full_q%0d got %h want %h", i, st, ex); end
    end
    step();
    ex = {4'b0100, 1'b1, 8'd255, 1'b1, 4'b0100};
    n_cmp++; if (st !== ex) begin n_err++; $display("FAIL full_done got %h want %h", st, ex); end
    step();
    ex = {4'b0000, 1'b0, 8'd255, 1'b0, 4'b0000};
    n_cmp++; if (st !== ex) begin n_err++; $display("FAIL full_idle got %h want %h", st, ex); end
  endtask
  task automatic test_reset_mid_run();
    load_val[0 +: CW] = 8'd10;
    req = 4'b0001;
    step();
    step();
    step();
    ex = {4'b0001, 1'b1, 8'd2, 1'b0, 4'b0000};
    n_cmp++; if (st !== ex) begin n_err++; $display("FAIL rstmid_pre got %h want %h", st, ex); end
    #3 reset_n = 1'b0;
    #1;
    n_cmp++; if (st !== 18'd0) begin n_err++; $display("FAIL rstmid_async got %h want %h", st, 18'd0); end
    n_cmp++; if (owner !== 2'd3) begin n_err++; $display("FAIL rstmid_owner got %0d want 3", owner); end
    #2 reset_n = 1'b1;
    req = 4'b0011;
    step();
    ex = {4'b0001, 1'b1, 8'd0, 1'b0, 4'b0000};
    n_cmp++; if (st !== ex) begin n_err++; $display("FAIL rstmid_regrant got %h want %h", st, ex); end
    n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL rstmid_newowner got %0d want 0", owner); end
    abort = 1'b1;
    req = 4'b0000;
    step();
    abort = 1'b0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_tc0();
    test_round_robin();
    test_abort();
    test_full_range();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
